ahfp_cordic_seq: RTL and testbench

Iterative, parametrised single-precision floating-point CORDIC (rotation mode) that returns cos(theta) and sin(theta) for one IEEE-754 angle per transaction. It is the successor to the fixed 10-stage unrolled rotator. Its differences from that block:

- configurable iteration count;
- built-in gain compensation;
- quadrant correction for |theta| up to pi;
- NaN/Inf/range detection;
- valid/ready handshakes on input and output.

It time-multiplexes three instances of the team's combinational adder ahfp_add_sub (result = dataa + datab) over N_ITER cycles.

---
 rtl/ahfp_cordic_seq.sv | 249 ++++++++++++++++++++++++
 tb/tb_ahfp_cordic_seq.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ahfp_cordic_seq.sv
// ahfp_cordic_seq: iterative fp32 CORDIC (rotation mode) returning cos/sin of one angle
// per transaction. Also holds ahfp_add_sub, the combinational fp32 adder it reuses.

// ahfp_add_sub: result = dataa + datab in fp32. Denormal inputs flush to zero,
// results round to nearest-even, and any Inf/NaN operand yields a quiet NaN.
module ahfp_add_sub (
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result
);

  logic        a_big;
  logic [31:0] big_v;
  logic [31:0] small_v;
  logic [23:0] m_big;
  logic [23:0] m_small;
  logic [7:0]  diff;
  logic [48:0] al_big;
  logic [48:0] al_small;
  logic [48:0] sum;
  logic [5:0]  lead;
  logic [48:0] norm;
  logic        rnd;
  int          ex;
  logic [30:0] packed_mag;

  // Align, add/subtract, normalise and round the two operands.
  always_comb begin
    a_big      = dataa[30:0] >= datab[30:0];
    big_v      = a_big ? dataa : datab;
    small_v    = a_big ? datab : dataa;
    m_big      = (big_v[30:23] != 8'd0) ? {1'b1, big_v[22:0]} : 24'd0;
    m_small    = (small_v[30:23] != 8'd0) ? {1'b1, small_v[22:0]} : 24'd0;
    diff       = big_v[30:23] - small_v[30:23];
    al_big     = {1'b0, m_big, 24'd0};
    al_small   = {1'b0, m_small, 24'd0} >> diff;
    sum        = (big_v[31] == small_v[31]) ? (al_big + al_small) : (al_big - al_small);
    lead       = 6'd0;
    for (int i = 0; i < 49; i++) begin
      if (sum[i]) lead = 6'(i);
    end
    norm       = sum << (6'd48 - lead);
    // Round to nearest, ties to even: guard bit plus sticky or lsb.
    rnd        = norm[24] & ((|norm[23:0]) | norm[25]);
    ex         = int'(big_v[30:23]) + int'(lead) - 47;
    packed_mag = {ex[7:0], norm[47:25]} + {30'd0, rnd};
    if (dataa[30:23] == 8'hFF || datab[30:23] == 8'hFF) begin
      result = 32'h7FC00000;
    end else if (!norm[48] || m_big == 24'd0) begin
      result = 32'h00000000;
    end else if (ex <= 0) begin
      result = {big_v[31], 31'd0};
    end else if (ex >= 255) begin
      result = {big_v[31], 8'hFF, 23'd0};
    end else begin
      result = {big_v[31], packed_mag};
    end
  end

endmodule

// Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
// in_ready is high only in IDLE; out_valid is high only in DONE and the result is held
// unchanged until out_ready is seen. One angle is in flight at a time.
module ahfp_cordic_seq #(
  parameter int          N_ITER = 16,
  parameter logic [31:0] K_GAIN = 32'h3F1B74EE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] theta,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] cos_out,
  output logic [31:0] sin_out,
  output logic        range_err
);

  if (N_ITER < 4 || N_ITER > 24) begin : g_bad_n_iter
    $error("ahfp_cordic_seq: N_ITER must lie in 4..24");
  end

  localparam logic [31:0] PI_F     = 32'h40490FDB;
  localparam logic [31:0] NEG_PI_F = 32'hC0490FDB;
  localparam logic [31:0] HALF_PI  = 32'h3FC90FDB;
  localparam logic [31:0] QNAN     = 32'h7FC00000;
  localparam logic [4:0]  CNT_LAST = 5'(N_ITER - 1);

  typedef enum logic [1:0] {IDLE, PRE, ITER, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [4:0]  cnt;
  logic [31:0] theta_q;
  logic [31:0] x;
  logic [31:0] y;
  logic [31:0] z;
  logic        flip;

  logic        d;
  logic [31:0] shx;
  logic [31:0] shy;
  logic [31:0] atan_i;
  logic [31:0] x_addend;
  logic [31:0] y_addend;
  logic [31:0] z_a;
  logic [31:0] z_b;
  logic [31:0] x_sum;
  logic [31:0] y_sum;
  logic [31:0] z_sum;
  logic        pre_err;
  logic        pre_flip;
  logic        last;

  // Multiply by 2^-i through the exponent; anything that would go subnormal becomes zero.
  function automatic logic [31:0] sh(input logic [31:0] v, input logic [4:0] i);
    if (v[30:23] > {3'b000, i}) sh = {v[31], v[30:23] - {3'b000, i}, v[22:0]};
    else                        sh = 32'h00000000;
  endfunction

  // atan(2^-i), fp32 round-to-nearest; from i=12 on this equals 2^-i exactly.
  function automatic logic [31:0] atan_rom(input logic [4:0] i);
    case (i)
      5'd0:    atan_rom = 32'h3F490FDB;
      5'd1:    atan_rom = 32'h3EED6338;
      5'd2:    atan_rom = 32'h3E7ADBB0;
      5'd3:    atan_rom = 32'h3DFEADD5;
      5'd4:    atan_rom = 32'h3D7FAADE;
      5'd5:    atan_rom = 32'h3CFFEAAE;
      5'd6:    atan_rom = 32'h3C7FFAAB;
      5'd7:    atan_rom = 32'h3BFFFEAB;
      5'd8:    atan_rom = 32'h3B7FFFAB;
      5'd9:    atan_rom = 32'h3AFFFFEB;
      5'd10:   atan_rom = 32'h3A7FFFFB;
      5'd11:   atan_rom = 32'h39FFFFFF;
      5'd12:   atan_rom = 32'h39800000;
      5'd13:   atan_rom = 32'h39000000;
      5'd14:   atan_rom = 32'h38800000;
      5'd15:   atan_rom = 32'h38000000;
      5'd16:   atan_rom = 32'h37800000;
      5'd17:   atan_rom = 32'h37000000;
      5'd18:   atan_rom = 32'h36800000;
      5'd19:   atan_rom = 32'h36000000;
      5'd20:   atan_rom = 32'h35800000;
      5'd21:   atan_rom = 32'h35000000;
      5'd22:   atan_rom = 32'h34800000;
      5'd23:   atan_rom = 32'h34000000;
      default: atan_rom = 32'h00000000;
    endcase
  endfunction

  // Operand selection for the three shared adders; the z adder also does the quadrant fold in PRE.
  always_comb begin
    d        = ~z[31];
    shx      = sh(x, cnt);
    shy      = sh(y, cnt);
    atan_i   = atan_rom(cnt);
    x_addend = d ? {~shy[31], shy[30:0]} : shy;
    y_addend = d ? shx : {~shx[31], shx[30:0]};
    pre_err  = (theta_q[30:23] == 8'hFF) || (theta_q[30:0] > PI_F[30:0]);
    pre_flip = theta_q[30:0] > HALF_PI[30:0];
    last     = (cnt == CNT_LAST);
    if (state == PRE) begin
      z_a = theta_q;
      z_b = theta_q[31] ? PI_F : NEG_PI_F;
    end else begin
      z_a = z;
      z_b = d ? {~atan_i[31], atan_i[30:0]} : atan_i;
    end
  end

  ahfp_add_sub u_add_x (.dataa(x),   .datab(x_addend), .result(x_sum));
  ahfp_add_sub u_add_y (.dataa(y),   .datab(y_addend), .result(y_sum));
  ahfp_add_sub u_add_z (.dataa(z_a), .datab(z_b),      .result(z_sum));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = PRE;
      PRE:     state_nxt = pre_err ? DONE : ITER;
      ITER:    if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state; in_ready is forced low while reset is held.
  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == DONE);
  end

  // Datapath: angle capture, quadrant fold, micro-rotations and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= 5'd0;
      theta_q   <= 32'h00000000;
      x         <= 32'h00000000;
      y         <= 32'h00000000;
      z         <= 32'h00000000;
      flip      <= 1'b0;
      cos_out   <= 32'h00000000;
      sin_out   <= 32'h00000000;
      range_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) theta_q <= theta;
        end
        PRE: begin
          if (pre_err) begin
            cos_out   <= QNAN;
            sin_out   <= QNAN;
            range_err <= 1'b1;
          end else begin
            z    <= pre_flip ? z_sum : theta_q;
            flip <= pre_flip;
            x    <= K_GAIN;
            y    <= 32'h00000000;
            cnt  <= 5'd0;
          end
        end
        ITER: begin
          x <= x_sum;
          y <= y_sum;
          z <= z_sum;
          if (last) begin
            cos_out   <= flip ? {~x_sum[31], x_sum[30:0]} : x_sum;
            sin_out   <= flip ? {~y_sum[31], y_sum[30:0]} : y_sum;
            range_err <= 1'b0;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ahfp_cordic_seq.sv
// Directed bench for ahfp_cordic_seq: latency, accuracy, range errors, backpressure, reset abort.
module tb_ahfp_cordic_seq;

  localparam int  N_ITER = 16;
  localparam real TOL    = 1.0 / 16384.0;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] theta;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] cos_out;
  logic [31:0] sin_out;
  logic        range_err;

  int n_checks;
  int n_fail;

  logic [31:0] exp_q[$];

  ahfp_cordic_seq #(.N_ITER(N_ITER), .K_GAIN(32'h3F1B74EE)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .theta(theta),
    .out_valid(out_valid), .out_ready(out_ready),
    .cos_out(cos_out), .sin_out(sin_out), .range_err(range_err)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, limit 300000 required less");
    $fatal(1, "watchdog");
  end

  function automatic real fp2r(input logic [31:0] v);
    real m;
    int  e;
    if (v[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(v[22:0]) / 8388608.0;
    e = int'(v[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return v[31] ? -m : m;
  endfunction

  function automatic real u2r(input logic [31:0] v);
    return real'(longint'({32'd0, v}));
  endfunction

  task automatic check(input string tag, input real obs, input real exp_v, input real tol);
    n_checks++;
    if (obs > exp_v + tol || obs < exp_v - tol) begin
      n_fail++;
      $display("FAIL %s: got %0.7f expected %0.7f (tol %0.7f)", tag, obs, exp_v, tol);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an angle and hold it until accepted; returns edges spent including the accept edge.
  task automatic send(input logic [31:0] th, output int edges);
    int waits;
    waits    = 0;
    in_valid = 1'b1;
    theta    = th;
    while (!in_ready && waits < 100) begin
      tick();
      waits++;
    end
    tick();
    in_valid = 1'b0;
    theta    = $urandom_range(0, 32'h7FFFFFFF);
    edges    = waits + 1;
  endtask

  // Count edges until out_valid and score the latency against the queued expectation.
  task automatic wait_out(input string tag, output int lat);
    logic [31:0] exp_lat;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!out_valid && lat < 100);
    exp_lat = exp_q.pop_front();
    check({tag, "_lat"}, real'(lat), real'(exp_lat), 0.0);
  endtask

  task automatic run_angle(input string tag, input logic [31:0] th,
                           input real ec, input real es, input logic err);
    int edges;
    int lat;
    exp_q.push_back(err ? 32'd1 : 32'(N_ITER + 1));
    send(th, edges);
    wait_out(tag, lat);
    check({tag, "_err"}, real'(range_err), real'(err), 0.0);
    if (err) begin
      check({tag, "_cos"}, u2r(cos_out), u2r(32'h7FC00000), 0.0);
      check({tag, "_sin"}, u2r(sin_out), u2r(32'h7FC00000), 0.0);
    end else begin
      check({tag, "_cos"}, fp2r(cos_out), ec, TOL);
      check({tag, "_sin"}, fp2r(sin_out), es, TOL);
    end
  endtask

  initial begin
    int          edges;
    int          lat;
    int          ov_seen;
    logic [31:0] c0;
    logic [31:0] s0;
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    theta     = 32'h0;
    out_ready = 1'b1;

    // Reset
    tick(); tick(); tick();
    check("rst_in_ready", real'(in_ready), 0.0, 0.0);
    check("rst_out_valid", real'(out_valid), 0.0, 0.0);
    check("rst_cos", u2r(cos_out), 0.0, 0.0);
    check("rst_sin", u2r(sin_out), 0.0, 0.0);
    check("rst_range_err", real'(range_err), 0.0, 0.0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", real'(in_ready), 1.0, 0.0);

    // Normal-path directed angles
    run_angle("zero", 32'h00000000, 1.0, 0.0, 1'b0);
    run_angle("half_pi", 32'h3FC90FDB, 0.0, 1.0, 1'b0);
    run_angle("three", 32'h40400000, -0.9899924966, 0.1411200081, 1'b0);
    run_angle("neg_three", 32'hC0400000, -0.9899924966, -0.1411200081, 1'b0);
    run_angle("one", 32'h3F800000, 0.5403023059, 0.8414709848, 1'b0);

    // Initiation interval with out_ready high: last run ended at its out_valid edge
    send(32'h3F000000, edges);
    check("ii", real'(N_ITER + 1 + edges), real'(N_ITER + 3), 0.0);
    exp_q.push_back(32'(N_ITER + 1));
    wait_out("half", lat);
    check("half_cos", fp2r(cos_out), 0.8775825619, TOL);
    check("half_sin", fp2r(sin_out), 0.4794255386, TOL);

    // Range errors
    run_angle("four", 32'h40800000, 0.0, 0.0, 1'b1);
    run_angle("inf", 32'h7F800000, 0.0, 0.0, 1'b1);
    run_angle("nan", 32'h7FC00001, 0.0, 0.0, 1'b1);
    run_angle("neg_four", 32'hC0800000, 0.0, 0.0, 1'b1);
    run_angle("after_err", 32'h00000000, 1.0, 0.0, 1'b0);
    tick();

    // Backpressure, with a second angle presented while the result is held
    out_ready = 1'b0;
    exp_q.push_back(32'(N_ITER + 1));
    send(32'h3F000000, edges);
    wait_out("bp", lat);
    check("bp_cos", fp2r(cos_out), 0.8775825619, TOL);
    check("bp_sin", fp2r(sin_out), 0.4794255386, TOL);
    c0       = cos_out;
    s0       = sin_out;
    in_valid = 1'b1;
    theta    = 32'h3F800000;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", real'(out_valid), 1.0, 0.0);
      check("bp_hold_in_ready", real'(in_ready), 0.0, 0.0);
      check("bp_hold_cos", u2r(cos_out), u2r(c0), 0.0);
      check("bp_hold_sin", u2r(sin_out), u2r(s0), 0.0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", real'(out_valid), 0.0, 0.0);
    check("bp_release_in_ready", real'(in_ready), 1.0, 0.0);
    tick();
    in_valid = 1'b0;
    check("bp_second_taken", real'(in_ready), 0.0, 0.0);
    exp_q.push_back(32'(N_ITER + 1));
    wait_out("bp2", lat);
    check("bp2_cos", fp2r(cos_out), 0.5403023059, TOL);
    check("bp2_sin", fp2r(sin_out), 0.8414709848, TOL);
    tick();

    // Reset while iterating (counter at 5)
    send(32'h40400000, edges);
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1;
    tick();
    check("mid_rst_in_ready", real'(in_ready), 0.0, 0.0);
    check("mid_rst_out_valid", real'(out_valid), 0.0, 0.0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", real'(in_ready), 1.0, 0.0);
    check("post_rst_cos", u2r(cos_out), 0.0, 0.0);
    ov_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) ov_seen++;
    end
    check("post_rst_no_valid", real'(ov_seen), 0.0, 0.0);
    run_angle("post_rst_zero", 32'h00000000, 1.0, 0.0, 1'b0);

    check("exp_q_empty", real'(exp_q.size()), 0.0, 0.0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
